// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, ALU operation encoding and operand/forward selectors
// used by the ALU issue stage and its decoder.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_EQ   = 4'b1000,
        ALU_NE   = 4'b1001,
        ALU_TRUE = 4'b1010,
        ALU_LT   = 4'b1100,
        ALU_GE   = 4'b1101,
        ALU_LTU  = 4'b1110,
        ALU_GEU  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_ZERO = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_WB   = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_ZERO = 2'd1,
        SRC_A_PC   = 2'd2
    } src_a_e;

    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } src_b_e;

    // Register-register and register-immediate share this table; only OP may select SUB.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic f7b5,
                                         input logic allow_sub);
        case (f3)
            3'b000:  arith_op = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_LT;
            3'b011:  arith_op = ALU_LTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute bundle of the ALU issue stage: decode handshake, bypass buses,
// flush and the registered execute-side outputs.
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
);
    logic                     id_valid;
    logic                     id_ready;
    logic [6:0]               id_opcode;
    logic [2:0]               id_funct3;
    logic                     id_funct7b5;
    logic [REG_ADDR_W-1:0]    id_rs1;
    logic [REG_ADDR_W-1:0]    id_rs2;
    logic [REG_ADDR_W-1:0]    id_rd;
    logic [DATA_WIDTH-1:0]    id_rs1_data;
    logic [DATA_WIDTH-1:0]    id_rs2_data;
    logic [DATA_WIDTH-1:0]    id_imm;
    logic [DATA_WIDTH-1:0]    id_pc;
    logic                     mem_fwd_we;
    logic [REG_ADDR_W-1:0]    mem_fwd_rd;
    logic [DATA_WIDTH-1:0]    mem_fwd_data;
    logic                     wb_fwd_we;
    logic [REG_ADDR_W-1:0]    wb_fwd_rd;
    logic [DATA_WIDTH-1:0]    wb_fwd_data;
    logic                     flush;
    logic                     ex_ready;
    logic                     ex_valid;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    ex_store_data;
    logic [REG_ADDR_W-1:0]    ex_rd;
    logic [DATA_WIDTH-1:0]    ex_pc;
    logic                     ex_is_branch;
    logic                     ex_is_jump;
    logic                     ex_illegal;

    modport master (
        output id_valid, id_opcode, id_funct3, id_funct7b5, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_pc,
               mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
               flush, ex_ready,
        input  id_ready, ex_valid, SrcA, SrcB, Operation, ex_store_data, ex_rd, ex_pc,
               ex_is_branch, ex_is_jump, ex_illegal
    );

    modport slave (
        input  id_valid, id_opcode, id_funct3, id_funct7b5, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_pc,
               mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
               flush, ex_ready,
        output id_ready, ex_valid, SrcA, SrcB, Operation, ex_store_data, ex_rd, ex_pc,
               ex_is_branch, ex_is_jump, ex_illegal
    );
endinterface

// File: rtl/alu_issue_stage_decode.sv
// Pure combinational RV32I decode: opcode/funct3/funct7[5] to ALU operation,
// operand selects and control flags.
module alu_op_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_op_e    op,
    output src_a_e     a_sel,
    output src_b_e     b_sel,
    output logic       writes_rd,
    output logic       is_branch,
    output logic       is_jump,
    output logic       illegal
);

    always_comb begin
        op        = ALU_ADD;
        a_sel     = SRC_A_RS1;
        b_sel     = SRC_B_RS2;
        writes_rd = 1'b1;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP:     op = arith_op(funct3, funct7b5, 1'b1);
            OPC_OP_IMM: begin
                b_sel = SRC_B_IMM;
                op    = arith_op(funct3, funct7b5, 1'b0);
            end
            OPC_LOAD:   b_sel = SRC_B_IMM;
            OPC_STORE: begin
                b_sel     = SRC_B_IMM;
                writes_rd = 1'b0;
            end
            OPC_BRANCH: begin
                writes_rd = 1'b0;
                is_branch = 1'b1;
                case (funct3)
                    3'b000:  op = ALU_EQ;
                    3'b001:  op = ALU_NE;
                    3'b100:  op = ALU_LT;
                    3'b101:  op = ALU_GE;
                    3'b110:  op = ALU_LTU;
                    3'b111:  op = ALU_GEU;
                    default: begin
                        // Reserved branch encodings are reported as illegal, not as branches.
                        op        = ALU_AND;
                        is_branch = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                op      = ALU_TRUE;
                is_jump = 1'b1;
            end
            OPC_LUI: begin
                a_sel = SRC_A_ZERO;
                b_sel = SRC_B_IMM;
            end
            OPC_AUIPC: begin
                a_sel = SRC_A_PC;
                b_sel = SRC_B_IMM;
            end
            default: begin
                op        = ALU_AND;
                writes_rd = 1'b0;
                illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: resolves operand forwarding, decodes the ALU operation and
// holds the execute-stage operands under stall and flush.
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_stage_if.slave bus
);

    fwd_sel_e              a_fsel, b_fsel;
    logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd;
    alu_op_e               dec_op;
    src_a_e                dec_a_sel;
    src_b_e                dec_b_sel;
    logic                  dec_writes_rd, dec_branch, dec_jump, dec_illegal;
    logic                  capture;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] src_a_q, src_a_d, src_b_q, src_b_d;
    logic [DATA_WIDTH-1:0] store_q, store_d, pc_q, pc_d;
    alu_op_e               op_q, op_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  branch_q, branch_d, jump_q, jump_d, illegal_q, illegal_d;

    function automatic fwd_sel_e pick_fwd(
        input logic [REG_ADDR_W-1:0] rs,
        input logic mem_we, input logic [REG_ADDR_W-1:0] mem_rd,
        input logic wb_we,  input logic [REG_ADDR_W-1:0] wb_rd);
        if (rs == '0)                     pick_fwd = FWD_ZERO;
        else if (mem_we && mem_rd == rs)  pick_fwd = FWD_MEM;
        else if (wb_we && wb_rd == rs)    pick_fwd = FWD_WB;
        else                              pick_fwd = FWD_RF;
    endfunction

    always_comb begin
        a_fsel = pick_fwd(bus.id_rs1, bus.mem_fwd_we, bus.mem_fwd_rd,
                          bus.wb_fwd_we, bus.wb_fwd_rd);
        b_fsel = pick_fwd(bus.id_rs2, bus.mem_fwd_we, bus.mem_fwd_rd,
                          bus.wb_fwd_we, bus.wb_fwd_rd);
        case (a_fsel)
            FWD_ZERO: rs1_fwd = '0;
            FWD_MEM:  rs1_fwd = bus.mem_fwd_data;
            FWD_WB:   rs1_fwd = bus.wb_fwd_data;
            default:  rs1_fwd = bus.id_rs1_data;
        endcase
        case (b_fsel)
            FWD_ZERO: rs2_fwd = '0;
            FWD_MEM:  rs2_fwd = bus.mem_fwd_data;
            FWD_WB:   rs2_fwd = bus.wb_fwd_data;
            default:  rs2_fwd = bus.id_rs2_data;
        endcase
    end

    alu_op_decode u_decode (
        .opcode    (bus.id_opcode),
        .funct3    (bus.id_funct3),
        .funct7b5  (bus.id_funct7b5),
        .op        (dec_op),
        .a_sel     (dec_a_sel),
        .b_sel     (dec_b_sel),
        .writes_rd (dec_writes_rd),
        .is_branch (dec_branch),
        .is_jump   (dec_jump),
        .illegal   (dec_illegal)
    );

    assign bus.id_ready = !valid_q || bus.ex_ready;
    assign capture      = bus.id_valid && bus.id_ready && !bus.flush;

    always_comb begin
        valid_d   = valid_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        store_d   = store_q;
        pc_d      = pc_q;
        op_d      = op_q;
        rd_d      = rd_q;
        branch_d  = branch_q;
        jump_d    = jump_q;
        illegal_d = illegal_q;
        // Flush and plain consume only drop valid; the data fields keep their last value.
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            case (dec_a_sel)
                SRC_A_ZERO: src_a_d = '0;
                SRC_A_PC:   src_a_d = bus.id_pc;
                default:    src_a_d = rs1_fwd;
            endcase
            src_b_d   = (dec_b_sel == SRC_B_IMM) ? bus.id_imm : rs2_fwd;
            store_d   = rs2_fwd;
            pc_d      = bus.id_pc;
            op_d      = dec_op;
            rd_d      = dec_writes_rd ? bus.id_rd : '0;
            branch_d  = dec_branch;
            jump_d    = dec_jump;
            illegal_d = dec_illegal;
        end else if (bus.ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            store_q   <= '0;
            pc_q      <= '0;
            op_q      <= ALU_AND;
            rd_q      <= '0;
            branch_q  <= 1'b0;
            jump_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            store_q   <= store_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            branch_q  <= branch_d;
            jump_q    <= jump_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.ex_valid      = valid_q;
    assign bus.SrcA          = src_a_q;
    assign bus.SrcB          = src_b_q;
    assign bus.Operation     = OPCODE_LENGTH'(op_q);
    assign bus.ex_store_data = store_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_is_branch  = branch_q;
    assign bus.ex_is_jump    = jump_q;
    assign bus.ex_illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by random
// traffic compared against an instruction-level reference model.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)) bus ();

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] store;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        br;
        logic        jmp;
        logic        ill;
    } exp_t;

    exp_t exp_s;
    int   tests = 0;
    int   fails = 0;

    // Operation codes by funct3 for register ops (no SUB/SRA) and for branches.
    logic [3:0] arith_tab [8] = '{4'd2, 4'd4, 4'd12, 4'd14, 4'd3, 4'd5, 4'd1, 4'd0};
    logic [3:0] br_tab    [8] = '{4'd8, 4'd9, 4'd0, 4'd0, 4'd12, 4'd13, 4'd14, 4'd15};
    logic [6:0] opc_list  [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                   7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] fwd_val(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (bus.mem_fwd_we && bus.mem_fwd_rd == rs) return bus.mem_fwd_data;
        if (bus.wb_fwd_we && bus.wb_fwd_rd == rs) return bus.wb_fwd_data;
        return rf;
    endfunction

    function automatic exp_t predict();
        exp_t r;
        logic [2:0] f3;
        f3      = bus.id_funct3;
        r       = '0;
        r.valid = 1'b1;
        r.a     = fwd_val(bus.id_rs1, bus.id_rs1_data);
        r.b     = fwd_val(bus.id_rs2, bus.id_rs2_data);
        r.store = r.b;
        r.pc    = bus.id_pc;
        r.rd    = bus.id_rd;
        case (bus.id_opcode)
            7'h33: begin
                r.op = arith_tab[f3];
                if (bus.id_funct7b5 && f3 == 3'd0) r.op = 4'd6;
                if (bus.id_funct7b5 && f3 == 3'd5) r.op = 4'd7;
            end
            7'h13: begin
                r.b  = bus.id_imm;
                r.op = arith_tab[f3];
                if (bus.id_funct7b5 && f3 == 3'd5) r.op = 4'd7;
            end
            7'h03: begin r.b = bus.id_imm; r.op = 4'd2; end
            7'h23: begin r.b = bus.id_imm; r.op = 4'd2; r.rd = 5'd0; end
            7'h63: begin
                r.rd = 5'd0;
                if (f3 == 3'd2 || f3 == 3'd3) r.ill = 1'b1;
                else begin r.br = 1'b1; r.op = br_tab[f3]; end
            end
            7'h6F, 7'h67: begin r.op = 4'd10; r.jmp = 1'b1; end
            7'h37: begin r.a = 32'd0; r.b = bus.id_imm; r.op = 4'd2; end
            7'h17: begin r.a = bus.id_pc; r.b = bus.id_imm; r.op = 4'd2; end
            default: begin r.ill = 1'b1; r.op = 4'd0; r.rd = 5'd0; end
        endcase
        return r;
    endfunction

    // One clock: check id_ready, advance the model, compare every output after the edge.
    task automatic step();
        exp_t nx;
        logic rdy;
        #1;
        rdy = !exp_s.valid || bus.ex_ready;
        chk("id_ready", {31'd0, bus.id_ready}, {31'd0, rdy});
        nx = exp_s;
        if (reset) nx = '0;
        else if (bus.flush) nx.valid = 1'b0;
        else if (bus.id_valid && rdy) nx = predict();
        else if (bus.ex_ready) nx.valid = 1'b0;
        @(posedge clk);
        #1;
        exp_s = nx;
        chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, exp_s.valid});
        chk("SrcA", bus.SrcA, exp_s.a);
        chk("SrcB", bus.SrcB, exp_s.b);
        chk("Operation", {28'd0, bus.Operation}, {28'd0, exp_s.op});
        chk("store", bus.ex_store_data, exp_s.store);
        chk("ex_rd", {27'd0, bus.ex_rd}, {27'd0, exp_s.rd});
        chk("ex_pc", bus.ex_pc, exp_s.pc);
        chk("flags", {29'd0, bus.ex_is_branch, bus.ex_is_jump, bus.ex_illegal},
            {29'd0, exp_s.br, exp_s.jmp, exp_s.ill});
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2);
        bus.id_opcode   = opc;
        bus.id_funct3   = f3;
        bus.id_funct7b5 = f7;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_rs1_data = d1;
        bus.id_rs2_data = d2;
    endtask

    initial begin
        logic [31:0] held_a, held_b;
        exp_s            = '0;
        reset            = 1'b1;
        bus.id_valid     = 1'b0;
        bus.flush        = 1'b0;
        bus.ex_ready     = 1'b1;
        bus.id_imm       = 32'd0;
        bus.id_pc        = 32'd0;
        bus.mem_fwd_we   = 1'b0;
        bus.mem_fwd_rd   = 5'd0;
        bus.mem_fwd_data = 32'd0;
        bus.wb_fwd_we    = 1'b0;
        bus.wb_fwd_rd    = 5'd0;
        bus.wb_fwd_data  = 32'd0;
        set_instr(7'h33, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        step();
        step();
        chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_op", {28'd0, bus.Operation}, 32'd0);

        // ADD x3,x1,x2
        reset = 1'b0;
        bus.id_valid = 1'b1;
        set_instr(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        step();
        chk("add_a", bus.SrcA, 32'd5);
        chk("add_b", bus.SrcB, 32'd7);
        chk("add_op", {28'd0, bus.Operation}, 32'b0010);
        chk("add_rd", {27'd0, bus.ex_rd}, 32'd3);

        // SUB with both bypasses targeting x1: MEM wins
        set_instr(7'h33, 3'd0, 1'b1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7);
        bus.mem_fwd_we = 1'b1; bus.mem_fwd_rd = 5'd1; bus.mem_fwd_data = 32'd20;
        bus.wb_fwd_we  = 1'b1; bus.wb_fwd_rd  = 5'd1; bus.wb_fwd_data  = 32'd9;
        step();
        chk("sub_mem_prio", bus.SrcA, 32'd20);
        chk("sub_op", {28'd0, bus.Operation}, 32'b0110);

        // BLTU x0,x2 with a bypass writing x0
        set_instr(7'h63, 3'b110, 1'b0, 5'd0, 5'd2, 5'd9, 32'd77, 32'd7);
        bus.mem_fwd_rd = 5'd0; bus.mem_fwd_data = 32'd55;
        bus.wb_fwd_rd  = 5'd0;
        step();
        chk("bltu_op", {28'd0, bus.Operation}, 32'b1110);
        chk("bltu_br", {31'd0, bus.ex_is_branch}, 32'd1);
        chk("bltu_rd", {27'd0, bus.ex_rd}, 32'd0);
        chk("x0_zero", bus.SrcA, 32'd0);
        bus.mem_fwd_we = 1'b0; bus.wb_fwd_we = 1'b0;

        // Stall for three cycles, then release
        set_instr(7'h33, 3'd0, 1'b0, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22);
        step();
        held_a = bus.SrcA; held_b = bus.SrcB;
        bus.ex_ready = 1'b0;
        set_instr(7'h33, 3'b100, 1'b0, 5'd8, 5'd9, 5'd10, 32'hAA, 32'hBB);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", {31'd0, bus.id_ready}, 32'd0);
            chk("stall_a", bus.SrcA, held_a);
            chk("stall_b", bus.SrcB, held_b);
        end
        bus.ex_ready = 1'b1;
        step();
        chk("release_op", {28'd0, bus.Operation}, 32'b0011);
        chk("release_a", bus.SrcA, 32'hAA);

        // Flush with an incoming instruction
        bus.flush = 1'b1;
        step();
        chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        bus.flush = 1'b0;

        // Reset while stalled
        step();
        bus.ex_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("rst_stall_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_stall_a", bus.SrcA, 32'd0);
        reset = 1'b0;
        bus.id_valid = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, bus.id_ready}, 32'd1);
        step();

        // AUIPC and an unknown opcode
        bus.ex_ready = 1'b1;
        bus.id_valid = 1'b1;
        bus.id_pc = 32'h100; bus.id_imm = 32'h2000;
        set_instr(7'h17, 3'd0, 1'b0, 5'd3, 5'd4, 5'd5, 32'h1234, 32'h5678);
        step();
        chk("auipc_a", bus.SrcA, 32'h100);
        chk("auipc_b", bus.SrcB, 32'h2000);
        chk("auipc_op", {28'd0, bus.Operation}, 32'b0010);
        set_instr(7'h7F, 3'd0, 1'b0, 5'd3, 5'd4, 5'd5, 32'h1, 32'h2);
        step();
        chk("illegal", {31'd0, bus.ex_illegal}, 32'd1);
        chk("illegal_valid", {31'd0, bus.ex_valid}, 32'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset            = ($urandom_range(0, 63) == 0);
            bus.flush        = ($urandom_range(0, 15) == 0);
            bus.ex_ready     = ($urandom_range(0, 9) < 7);
            bus.id_valid     = ($urandom_range(0, 3) != 0);
            bus.id_opcode    = opc_list[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) bus.id_opcode = 7'($urandom);
            bus.id_funct3    = 3'($urandom);
            bus.id_funct7b5  = 1'($urandom);
            bus.id_rs1       = 5'($urandom_range(0, 4));
            bus.id_rs2       = 5'($urandom_range(0, 4));
            bus.id_rd        = 5'($urandom);
            bus.id_rs1_data  = $urandom;
            bus.id_rs2_data  = $urandom;
            bus.id_imm       = $urandom;
            bus.id_pc        = $urandom;
            bus.mem_fwd_we   = 1'($urandom);
            bus.mem_fwd_rd   = 5'($urandom_range(0, 4));
            bus.mem_fwd_data = $urandom;
            bus.wb_fwd_we    = 1'($urandom);
            bus.wb_fwd_rd    = 5'($urandom_range(0, 4));
            bus.wb_fwd_data  = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
